// File: rtl/frame_flip_reader_if.sv
`default_nettype none
// ============================================================================
//  Module   : frame_flip_reader_if
//  Purpose  : Bundles the frame-buffer read port and the downstream pixel
//             stream of frame_flip_reader into one interface.
//  Signals  : mem_addr  - linear frame-buffer address (ADDR_W bits)
//             mem_rd    - read strobe
//             mem_data  - read data, combinational while mem_rd is high
//             pix_valid / pix_ready - pixel stream handshake
//             pix_data  - 1-bit output pixel
//             pix_sof / pix_eol / pix_eof - frame/row markers
//  Modports : master (the reader), slave (memory + sink side)
//  Revision : 1.0 - initial release
// ============================================================================
interface frame_flip_reader_if #(
    parameter int ADDR_W = 24
) ();
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic              mem_data;
    logic              pix_valid;
    logic              pix_ready;
    logic              pix_data;
    logic              pix_sof;
    logic              pix_eol;
    logic              pix_eof;

    modport master (
        output mem_addr, mem_rd, pix_valid, pix_data, pix_sof, pix_eol, pix_eof,
        input  mem_data, pix_ready
    );

    modport slave (
        input  mem_addr, mem_rd, pix_valid, pix_data, pix_sof, pix_eol, pix_eof,
        output mem_data, pix_ready
    );
endinterface
`default_nettype wire

// File: rtl/frame_flip_reader.sv
`default_nettype none
// ============================================================================
//  Module   : frame_flip_reader
//  Purpose  : Read-side initiator for a 1-bit frame buffer. On start it scans
//             one WIDTH x HEIGHT frame in raster output order, optionally
//             mirroring columns (flip_h) and/or rows (flip_v) by generating
//             mirrored source addresses, and streams the pixels out over a
//             valid/ready handshake. Two cycles per pixel (READ, SEND).
//  Ports    : clk, rst          - clock, synchronous active-high reset
//             start             - begin a frame scan (only honoured in IDLE)
//             flip_h, flip_v    - mirror controls, latched on accepted start
//             invert            - (PIX_INVERT_EN only) invert captured pixels,
//                                 latched on accepted start
//             busy              - high from accepted start to last handshake
//             done              - one-cycle pulse after the last handshake
//             bus (master)      - frame-buffer read port + pixel stream
//  Options  : define PIX_INVERT_EN to add the invert port.
//  Revision : 1.0 - initial release
// ============================================================================
module frame_flip_reader #(
    parameter int WIDTH  = 320,
    parameter int HEIGHT = 240,
    parameter int ADDR_W = 24
) (
    input  wire logic          clk,
    input  wire logic          rst,
    input  wire logic          start,
    input  wire logic          flip_h,
    input  wire logic          flip_v,
`ifdef PIX_INVERT_EN
    input  wire logic          invert,
`endif
    output logic               busy,
    output logic               done,
    frame_flip_reader_if.master bus
);

    localparam int CX_W = $clog2(WIDTH + 1);
    localparam int CY_W = $clog2(HEIGHT + 1);

    localparam logic [CX_W-1:0]   X_LAST     = CX_W'(WIDTH - 1);
    localparam logic [CY_W-1:0]   Y_LAST     = CY_W'(HEIGHT - 1);
    localparam logic [ADDR_W-1:0] A_WIDTH    = ADDR_W'(WIDTH);
    localparam logic [ADDR_W-1:0] A_COL_LAST = ADDR_W'(WIDTH - 1);
    localparam logic [ADDR_W-1:0] A_ROW_LAST = ADDR_W'((HEIGHT - 1) * WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_SEND = 2'd2
    } state_t;

    state_t            state_q,    state_d;
    logic [CX_W-1:0]   ox_q,       ox_d;
    logic [CY_W-1:0]   oy_q,       oy_d;
    logic              flip_h_q,   flip_h_d;
    logic              flip_v_q,   flip_v_d;
    logic [ADDR_W-1:0] row_base_q, row_base_d;   // sy*WIDTH
    logic [ADDR_W-1:0] col_q,      col_d;        // sx
    logic [ADDR_W-1:0] addr_q,     addr_d;
    logic              data_q,     data_d;
    logic              sof_q,      sof_d;
    logic              eol_q,      eol_d;
    logic              eof_q,      eof_d;
    logic              done_q,     done_d;
    logic              cap_bit;

`ifdef PIX_INVERT_EN
    logic              invert_q,   invert_d;
    assign cap_bit = bus.mem_data ^ invert_q;
`else
    assign cap_bit = bus.mem_data;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            ox_q       <= '0;
            oy_q       <= '0;
            flip_h_q   <= 1'b0;
            flip_v_q   <= 1'b0;
            row_base_q <= '0;
            col_q      <= '0;
            addr_q     <= '0;
            data_q     <= 1'b0;
            sof_q      <= 1'b0;
            eol_q      <= 1'b0;
            eof_q      <= 1'b0;
            done_q     <= 1'b0;
`ifdef PIX_INVERT_EN
            invert_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            ox_q       <= ox_d;
            oy_q       <= oy_d;
            flip_h_q   <= flip_h_d;
            flip_v_q   <= flip_v_d;
            row_base_q <= row_base_d;
            col_q      <= col_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            sof_q      <= sof_d;
            eol_q      <= eol_d;
            eof_q      <= eof_d;
            done_q     <= done_d;
`ifdef PIX_INVERT_EN
            invert_q   <= invert_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        ox_d       = ox_q;
        oy_d       = oy_q;
        flip_h_d   = flip_h_q;
        flip_v_d   = flip_v_q;
        row_base_d = row_base_q;
        col_d      = col_q;
        addr_d     = addr_q;
        data_d     = data_q;
        sof_d      = sof_q;
        eol_d      = eol_q;
        eof_d      = eof_q;
        done_d     = 1'b0;
`ifdef PIX_INVERT_EN
        invert_d   = invert_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_READ;
                    flip_h_d   = flip_h;
                    flip_v_d   = flip_v;
`ifdef PIX_INVERT_EN
                    invert_d   = invert;
`endif
                    ox_d       = '0;
                    oy_d       = '0;
                    // Output pixel (0,0) maps to the mirrored corner.
                    row_base_d = flip_v ? A_ROW_LAST : '0;
                    col_d      = flip_h ? A_COL_LAST : '0;
                    addr_d     = row_base_d + col_d;
                end
            end

            S_READ: begin
                data_d  = cap_bit;
                sof_d   = (ox_q == '0) && (oy_q == '0);
                eol_d   = (ox_q == X_LAST);
                eof_d   = (ox_q == X_LAST) && (oy_q == Y_LAST);
                state_d = S_SEND;
            end

            S_SEND: begin
                if (bus.pix_ready) begin
                    if (eof_q) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_READ;
                        if (ox_q == X_LAST) begin
                            // Row wrap: step the row base by one row in the
                            // scan direction and restart the column term.
                            ox_d       = '0;
                            oy_d       = oy_q + CY_W'(1);
                            row_base_d = flip_v_q ? (row_base_q - A_WIDTH)
                                                  : (row_base_q + A_WIDTH);
                            col_d      = flip_h_q ? A_COL_LAST : '0;
                        end else begin
                            ox_d  = ox_q + CX_W'(1);
                            col_d = flip_h_q ? (col_q - ADDR_W'(1))
                                             : (col_q + ADDR_W'(1));
                        end
                        addr_d = row_base_d + col_d;
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    assign bus.mem_addr  = addr_q;
    assign bus.mem_rd    = (state_q == S_READ);
    assign bus.pix_valid = (state_q == S_SEND);
    assign bus.pix_data  = data_q;
    assign bus.pix_sof   = sof_q;
    assign bus.pix_eol   = eol_q;
    assign bus.pix_eof   = eof_q;
    assign busy          = (state_q != S_IDLE);
    assign done          = done_q;

endmodule
`default_nettype wire

// File: tb/tb_frame_flip_reader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_frame_flip_reader
//  Purpose  : Self-checking bench for frame_flip_reader at WIDTH=4, HEIGHT=3.
//             Directed table of flip cases, backpressure, reset abort,
//             back-to-back frames and randomized frames against a reference
//             address/pixel model.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_frame_flip_reader;

    localparam int W  = 4;
    localparam int H  = 3;
    localparam int N  = W * H;
    localparam int AW = 24;
`ifdef PIX_INVERT_EN
    localparam bit HAS_INV = 1'b1;
`else
    localparam bit HAS_INV = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start, flip_h, flip_v, invert, busy, done;
    logic [N-1:0] mem_bits;

    frame_flip_reader_if #(.ADDR_W(AW)) bus ();

    assign bus.mem_data = (bus.mem_addr < AW'(N)) ? mem_bits[bus.mem_addr[3:0]] : 1'b0;

    frame_flip_reader #(.WIDTH(W), .HEIGHT(H), .ADDR_W(AW)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .flip_h (flip_h),
        .flip_v (flip_v),
`ifdef PIX_INVERT_EN
        .invert (invert),
`endif
        .busy   (busy),
        .done   (done),
        .bus    (bus)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        logic        fh;
        logic        fv;
        logic [47:0] addrs;   // 4-bit address of output pixel k at [4k+:4]
    } vec_t;

    vec_t tbl [4];

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: output pixel k sits at (k%W, k/W); source is the mirror.
    function automatic logic [47:0] model_addrs(input logic fh, input logic fv);
        logic [47:0] r;
        int ox, oy, sx, sy;
        r = '0;
        for (int k = 0; k < N; k++) begin
            ox = k % W;
            oy = k / W;
            sx = fh ? (W - 1 - ox) : ox;
            sy = fv ? (H - 1 - oy) : oy;
            r[4*k +: 4] = 4'(sy * W + sx);
        end
        return r;
    endfunction

    // stall_sel: 0 none, 1 five-cycle stall on pixel 3, 2 random stalls.
    // abort_at : pixel index after whose handshake rst is pulsed (-1 none).
    // chain    : leave the DUT in its done cycle so the next frame starts there.
    task automatic run_frame(input logic fh, input logic fv, input logic inv,
                             input logic [47:0] exp, input int stall_sel,
                             input int abort_at, input bit noise, input bit chain);
        int st [N];
        int sum;
        int t0;
        logic [3:0] ea;
        logic ed;
        sum = 0;
        for (int k = 0; k < N; k++) begin
            if (stall_sel == 1)      st[k] = (k == 2) ? 5 : 0;
            else if (stall_sel == 2) st[k] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
            else                     st[k] = 0;
            sum += st[k];
        end

        start = 1'b1; flip_h = fh; flip_v = fv; invert = inv;
        bus.pix_ready = 1'b1;
        tick();
        t0 = cyc;
        start = 1'b0;
        check("busy_after_start", 32'(busy), 32'd1);

        for (int k = 0; k < N; k++) begin
            ea = exp[4*k +: 4];
            ed = mem_bits[ea] ^ inv;
            if (noise && k != N - 1) begin
                start  = 1'($urandom);
                flip_h = 1'($urandom);
                flip_v = 1'($urandom);
                invert = 1'($urandom);
            end else begin
                start = 1'b0;
            end
            check("mem_rd_read", 32'(bus.mem_rd), 32'd1);
            check("pix_valid_read", 32'(bus.pix_valid), 32'd0);
            check("mem_addr", 32'(bus.mem_addr), 32'(ea));
            tick();
            check("pix_valid", 32'(bus.pix_valid), 32'd1);
            check("mem_rd_send", 32'(bus.mem_rd), 32'd0);
            check("pix_data", 32'(bus.pix_data), 32'(ed));
            check("pix_sof", 32'(bus.pix_sof), 32'(k == 0));
            check("pix_eol", 32'(bus.pix_eol), 32'((k % W) == W - 1));
            check("pix_eof", 32'(bus.pix_eof), 32'(k == N - 1));
            if (st[k] > 0) begin
                bus.pix_ready = 1'b0;
                for (int s = 0; s < st[k]; s++) begin
                    tick();
                    check("stall_valid", 32'(bus.pix_valid), 32'd1);
                    check("stall_data", 32'(bus.pix_data), 32'(ed));
                    check("stall_flags", {29'd0, bus.pix_sof, bus.pix_eol, bus.pix_eof},
                          {29'd0, 1'(k == 0), 1'((k % W) == W - 1), 1'(k == N - 1)});
                    check("stall_mem_rd", 32'(bus.mem_rd), 32'd0);
                    check("stall_addr", 32'(bus.mem_addr), 32'(ea));
                end
                bus.pix_ready = 1'b1;
            end
            if (k == N - 1) start = 1'b0;
            tick();
            if (k == abort_at) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
                start = 1'b0;
                check("abort_busy", 32'(busy), 32'd0);
                check("abort_valid", 32'(bus.pix_valid), 32'd0);
                check("abort_done", 32'(done), 32'd0);
                check("abort_mem_rd", 32'(bus.mem_rd), 32'd0);
                check("abort_addr", 32'(bus.mem_addr), 32'd0);
                check("abort_data", 32'(bus.pix_data), 32'd0);
                for (int i = 0; i < 3; i++) begin
                    tick();
                    check("abort_no_done", 32'({busy, done}), 32'd0);
                end
                return;
            end
            if (k < N - 1) begin
                check("done_early", 32'(done), 32'd0);
            end else begin
                check("done_pulse", 32'(done), 32'd1);
                check("busy_end", 32'(busy), 32'd0);
                check("valid_end", 32'(bus.pix_valid), 32'd0);
                check("frame_cycles", 32'(cyc - t0), 32'(2 * N + sum));
            end
        end

        if (!chain) begin
            start = 1'b0;
            tick();
            check("done_one_cycle", 32'(done), 32'd0);
            check("idle_busy", 32'(busy), 32'd0);
        end
    endtask

    initial begin
        logic fh, fv, inv;
        tbl[0] = '{fh: 1'b0, fv: 1'b0, addrs: 48'hBA98_7654_3210};
        tbl[1] = '{fh: 1'b1, fv: 1'b0, addrs: 48'h89AB_4567_0123};
        tbl[2] = '{fh: 1'b0, fv: 1'b1, addrs: 48'h3210_7654_BA98};
        tbl[3] = '{fh: 1'b1, fv: 1'b1, addrs: 48'h0123_4567_89AB};

        rst = 1'b1; start = 1'b0; flip_h = 1'b0; flip_v = 1'b0; invert = 1'b0;
        bus.pix_ready = 1'b1;
        mem_bits = 12'hAAA;          // data = addr[0]
        tick();
        tick();
        rst = 1'b0;
        check("rst_addr", 32'(bus.mem_addr), 32'd0);
        check("rst_outs", {23'd0, bus.mem_rd, bus.pix_valid, bus.pix_data, bus.pix_sof,
                           bus.pix_eol, bus.pix_eof, busy, done, 1'b0}, 32'd0);
        tick();
        check("idle_no_start", 32'({busy, bus.mem_rd}), 32'd0);

        for (int i = 0; i < 4; i++)
            run_frame(tbl[i].fh, tbl[i].fv, 1'b0, tbl[i].addrs, 0, -1, 1'b0, 1'b0);

        run_frame(1'b0, 1'b0, 1'b0, tbl[0].addrs, 1, -1, 1'b0, 1'b0);   // backpressure
        run_frame(1'b0, 1'b0, 1'b0, tbl[0].addrs, 0, 4, 1'b0, 1'b0);    // reset after pixel 5
        run_frame(1'b0, 1'b0, 1'b0, tbl[0].addrs, 0, -1, 1'b0, 1'b1);   // rescan, chained
        run_frame(1'b1, 1'b1, 1'b0, tbl[3].addrs, 0, -1, 1'b0, 1'b0);   // started in done cycle

        if (HAS_INV)
            run_frame(1'b0, 1'b0, 1'b1, tbl[0].addrs, 0, -1, 1'b0, 1'b0);

        for (int r = 0; r < 20; r++) begin
            mem_bits = 12'($urandom);
            fh  = 1'($urandom);
            fv  = 1'($urandom);
            inv = HAS_INV ? 1'($urandom) : 1'b0;
            run_frame(fh, fv, inv, model_addrs(fh, fv), 2, -1, 1'b1, 1'($urandom));
        end
        start = 1'b0;
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/frame_flip_reader.md
# frame_flip_reader

Read-side initiator for the 1-bit frame buffer memory. On a start pulse it scans one WIDTH×HEIGHT frame out of the memory in raster output order. It applies an optional horizontal and/or vertical flip by generating mirrored source addresses. Pixels are streamed to the downstream sink through a valid/ready handshake. It sits between the frame buffer and the display/output path of the flip-and-invert image pipeline.

## Interface
- WIDTH, 320, frame width in pixels
- HEIGHT, 240, frame height in pixels
- ADDR_W, 24, memory address width; must hold WIDTH*HEIGHT-1

- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request one frame scan; sampled only in IDLE
- flip_h  in  1  mirror columns; latched on accepted start
- flip_v  in  1  mirror rows; latched on accepted start
- busy  out  1  high from accepted start until last pixel handshake
- done  out  1  one-cycle pulse after the last pixel handshake
- mem_addr  out  ADDR_W  linear source address = sy*WIDTH + sx
- mem_rd  out  1  read strobe to frame buffer
- mem_data  in  1  frame buffer read data, valid combinationally while mem_rd is high
- pix_valid  out  1  output pixel valid
- pix_ready  in  1  sink accepts pixel
- pix_data  out  1  output pixel
- pix_sof / pix_eol / pix_eof  out  1 each  first pixel of frame / last pixel of row / last pixel of frame; qualified by pix_valid

## Operation
- Output raster counters: ox in 0..WIDTH-1, oy in 0..HEIGHT-1.
- Source coordinates:
  - sx = flip_h ? WIDTH-1-ox : ox
  - sy = flip_v ? HEIGHT-1-oy : oy
- Address generation uses no multiplier.
  - A row_base register holds sy*WIDTH.
  - row_base steps by ±WIDTH at each row wrap.
  - The column term steps ±1 per pixel.
- States:
  - IDLE: mem_rd=0, pix_valid=0. On start go to READ; latch flips; ox=oy=0; busy=1.
  - READ: mem_rd=1, mem_addr valid. At the edge, pix_data<=mem_data, set flags, pix_valid<=1, go to SEND.
  - SEND: pix_valid=1, mem_rd=0.
    - On pix_ready with the last pixel: go to IDLE, done=1 for one cycle, busy=0.
    - On pix_ready otherwise: advance ox (wrap to 0 and increment oy at WIDTH-1), go to READ.
    - Without pix_ready: hold.
- pix_data and all flags stay stable while pix_valid=1 and pix_ready=0.
- start is ignored while busy. flip_h and flip_v changes mid-frame have no effect.
- rst in any state:
  - Next cycle is IDLE.
  - All outputs take their reset values; counters are cleared.
  - A partial frame is abandoned; no done pulse.
- No writes are ever issued; the block has no write port.

## Timing
- Reset values: mem_addr=0, mem_rd=0, pix_valid=0, pix_data=0, pix_sof=pix_eol=pix_eof=0, busy=0, done=0.
- Start is seen at edge N. mem_rd and mem_addr are asserted in cycle N+1. pix_valid is asserted from cycle N+2.
- Throughput: 2 cycles per pixel with pix_ready held high.
- A full frame takes 2*WIDTH*HEIGHT cycles from the start edge to the done pulse.
- mem_addr holds its last value when mem_rd=0.
- start asserted in the done cycle (state IDLE) is accepted; back-to-back frames are legal.
- WIDTH=1 or HEIGHT=1 must work: pix_eol on every pixel, or on the last pixel only, respectively.

## Configuration
- PIX_INVERT_EN defined:
  - Adds input port invert (1 bit), latched on accepted start.
  - Captured data is pix_data <= mem_data ^ invert_latched.
- PIX_INVERT_EN undefined:
  - No invert port; pix_data <= mem_data unmodified.
  - Timing and all other behaviour are identical in both builds.

## Test plan
Bench uses WIDTH=4, HEIGHT=3 and a memory model whose data = addr[0].
- No flip, pix_ready=1: mem_addr sequence is 0..11.
  - pix_data alternates 0,1.
  - pix_sof on the 1st pixel, pix_eol on pixels 4/8/12, pix_eof on the 12th.
  - done pulses 24 cycles after the start edge.
- flip_h=1: addresses 3,2,1,0,7,6,5,4,11,10,9,8.
- flip_v=1: addresses 8..11, 4..7, 0..3.
- flip_h=1, flip_v=1: addresses 11..0.
- Backpressure: pix_ready low for 5 cycles on pixel 3.
  - pix_valid stays high and pix_data stays stable.
  - mem_rd stays 0 and no address advances.
  - The sequence then resumes correctly.
- rst pulse after pixel 5:
  - Next cycle busy=0, pix_valid=0, no done pulse.
  - A new start rescans from address 0.
- With PIX_INVERT_EN and invert=1: pix_data is 1,0,1,0,…
